msrv32_wb_port_arbiter: RTL and testbench

// - Shares the single write port of the integer register file between NUM_REQ writeback requesters (ALU, load unit, CSR).
// - Round-robin arbitration with a valid/ready handshake per requester.
// - Registered output stage drives the register-file write port.
// - 32-entry pending-write scoreboard produces a stall flag for the decode-stage rs1/rs2 addresses.

---
 rtl/msrv32_wb_port_arbiter.sv | 115 +++++++++++
 tb/tb_msrv32_wb_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_wb_port_arbiter.sv
// Round-robin writeback arbiter for the integer register-file write port,
// with a pending-write scoreboard that stalls decode on busy sources.
module msrv32_wb_port_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic                      ms_riscv32_mp_clk_in,
   input  logic                      ms_riscv32_mp_rst_in,
   input  logic [NUM_REQ-1:0]        req_valid_in,
   input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr_in,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
   output logic [NUM_REQ-1:0]        req_ready_out,
   output logic                      wr_en_out,
   output logic [ADDR_W-1:0]         rd_addr_out,
   output logic [DATA_W-1:0]         rd_out,
   output logic [1:0]                grant_id_out,
   input  logic                      pend_set_in,
   input  logic [ADDR_W-1:0]         pend_addr_in,
   input  logic [ADDR_W-1:0]         rs_1_addr_in,
   input  logic [ADDR_W-1:0]         rs_2_addr_in,
   output logic                      stall_out
);

   localparam int DEPTH = 1 << ADDR_W;

   logic              rst;
   logic [1:0]        ptr;
   logic [1:0]        gidx;
   logic              found;
   logic              acc;
   logic [3:0]        vld4;
   logic [3:0]        rdy4;
   logic [2:0]        j;
   logic [2:0]        ptr_inc;
   logic [1:0]        ptr_nxt;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [DEPTH-1:0]  pend;
   logic [DEPTH-1:0]  pend_nxt;

   assign rst = ms_riscv32_mp_rst_in;

   // First valid requester at or after the pointer, wrapping.
   always_comb begin
      found = 1'b0;
      gidx  = 2'd0;
      rdy4  = 4'd0;
      j     = 3'd0;
      vld4  = 4'(req_valid_in);
      for (int k = 0; k < NUM_REQ; k++) begin
         j = 3'(ptr) + 3'(k);
         if (j >= 3'(NUM_REQ))
            j = j - 3'(NUM_REQ);
         if (!found && vld4[j[1:0]]) begin
            found = 1'b1;
            gidx  = j[1:0];
         end
      end
      if (found && !rst)
         rdy4[gidx] = 1'b1;
   end

   assign req_ready_out = rdy4[NUM_REQ-1:0];
   assign acc           = found & ~rst;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx == 2'(i)) begin
            sel_addr = req_rd_addr_in[i*ADDR_W +: ADDR_W];
            sel_data = req_data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   assign ptr_inc = 3'(gidx) + 3'd1;
   assign ptr_nxt = (ptr_inc == 3'(NUM_REQ)) ? 2'd0 : ptr_inc[1:0];

   // Set is applied after clear so a same-edge set on that address wins.
   always_comb begin
      pend_nxt = pend;
      if (acc && sel_addr != '0)
         pend_nxt[sel_addr] = 1'b0;
      if (pend_set_in && pend_addr_in != '0)
         pend_nxt[pend_addr_in] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         ptr          <= 2'd0;
         pend         <= '0;
         wr_en_out    <= 1'b0;
         rd_addr_out  <= '0;
         rd_out       <= '0;
         grant_id_out <= 2'd0;
      end else begin
         pend <= pend_nxt;
         if (acc) begin
            ptr          <= ptr_nxt;
            wr_en_out    <= (sel_addr != '0);
            rd_addr_out  <= sel_addr;
            rd_out       <= sel_data;
            grant_id_out <= gidx;
         end else begin
            wr_en_out <= 1'b0;
         end
      end
   end

   assign stall_out = ~rst & (pend[rs_1_addr_in] | pend[rs_2_addr_in]);

endmodule

// File: tb/tb_msrv32_wb_port_arbiter.sv
// Randomized and directed bench for the writeback port arbiter,
// checked against a queue-based reference model.
module tb_msrv32_wb_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    valid = '0;
   logic [N*AW-1:0] addr_bus = '0;
   logic [N*DW-1:0] data_bus = '0;
   logic [N-1:0]    ready;
   logic            wr_en;
   logic [AW-1:0]   rd_addr;
   logic [DW-1:0]   rd_data;
   logic [1:0]      gid;
   logic            pend_set = 1'b0;
   logic [AW-1:0]   pend_addr = '0;
   logic [AW-1:0]   rs1 = '0;
   logic [AW-1:0]   rs2 = '0;
   logic            stall;

   msrv32_wb_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .req_valid_in         (valid),
      .req_rd_addr_in       (addr_bus),
      .req_data_in          (data_bus),
      .req_ready_out        (ready),
      .wr_en_out            (wr_en),
      .rd_addr_out          (rd_addr),
      .rd_out               (rd_data),
      .grant_id_out         (gid),
      .pend_set_in          (pend_set),
      .pend_addr_in         (pend_addr),
      .rs_1_addr_in         (rs1),
      .rs_2_addr_in         (rs2),
      .stall_out            (stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        we;
      bit [4:0]  a;
      bit [31:0] d;
      bit [1:0]  g;
   } wr_t;

   wr_t       q[$];
   int        errors = 0;
   int        checks = 0;
   int        m_ptr  = 0;
   bit [31:0] m_pend = '0;
   wr_t       m_out  = '{1'b0, 5'd0, 32'd0, 2'd0};

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input bit v, input bit [4:0] a,
                          input bit [31:0] d);
      valid[i] = v;
      addr_bus[i*AW +: AW] = a;
      data_bus[i*DW +: DW] = d;
   endtask

   // One clock: check combinational outputs, advance the model,
   // queue the expected registered outputs for the monitor.
   task automatic cyc(output int g);
      int       j;
      bit [4:0] a;
      logic [N-1:0] er;
      @(negedge clk);
      g = -1;
      if (rst) begin
         check("ready_rst", ready, 0);
         check("stall_rst", stall, 0);
         m_ptr  = 0;
         m_pend = '0;
         m_out  = '{1'b0, 5'd0, 32'd0, 2'd0};
      end else begin
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && valid[j]) g = j;
         end
         er = '0;
         if (g >= 0) er[g] = 1'b1;
         check("ready", ready, er);
         check("stall", stall, m_pend[rs1] | m_pend[rs2]);
         if (g >= 0) begin
            a       = addr_bus[g*AW +: AW];
            m_out.we = (a != 0);
            m_out.a  = a;
            m_out.d  = data_bus[g*DW +: DW];
            m_out.g  = 2'(g);
            m_ptr   = (g + 1) % N;
            if (a != 0) m_pend[a] = 1'b0;
         end else begin
            m_out.we = 1'b0;
         end
         if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
      end
      q.push_back(m_out);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      wr_t e;
      #2;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("wr_en", wr_en, e.we);
         check("rd_addr", rd_addr, e.a);
         check("rd_data", rd_data, e.d);
         check("grant_id", gid, e.g);
      end
   end

   initial begin
      int g;
      bit [4:0] ra;
      rst = 1'b1;
      cyc(g);
      cyc(g);
      rst = 1'b0;
      cyc(g);
      cyc(g);

      set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
      cyc(g);
      set_req(1, 1'b0, 5'd0, 32'd0);
      cyc(g);
      cyc(g);

      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), $urandom);
      repeat (7) cyc(g);
      valid = '0;
      cyc(g);

      pend_set = 1'b1;
      pend_addr = 5'd7;
      cyc(g);
      pend_set = 1'b0;
      rs1 = 5'd7;
      cyc(g);
      cyc(g);
      set_req(0, 1'b1, 5'd7, 32'h0000_0077);
      cyc(g);
      valid = '0;
      cyc(g);
      pend_set = 1'b1;
      cyc(g);
      set_req(0, 1'b1, 5'd7, 32'h0000_0777);
      cyc(g);
      valid = '0;
      pend_set = 1'b0;
      cyc(g);
      cyc(g);
      set_req(0, 1'b1, 5'd7, 32'h0000_7777);
      cyc(g);
      valid = '0;
      cyc(g);

      set_req(2, 1'b1, 5'd0, 32'h0000_1234);
      rs1 = 5'd0;
      cyc(g);
      valid = '0;
      pend_set = 1'b1;
      pend_addr = 5'd0;
      cyc(g);
      pend_set = 1'b0;
      cyc(g);

      pend_set = 1'b1;
      pend_addr = 5'd12;
      rs2 = 5'd12;
      cyc(g);
      pend_set = 1'b0;
      set_req(1, 1'b1, 5'd9, 32'hCAFE_0009);
      cyc(g);
      valid = '0;
      #2;
      rst = 1'b1;
      #1;
      check("async_wr_en", wr_en, 0);
      check("async_rd_addr", rd_addr, 0);
      check("async_rd_data", rd_data, 0);
      check("async_ready", ready, 0);
      check("async_stall", stall, 0);
      cyc(g);
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 20), $urandom);
      cyc(g);
      check("restart_grant", g, 0);
      valid = '0;
      cyc(g);

      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!valid[i] && ($urandom % 2) == 1) begin
               ra = 5'($urandom % 32);
               if (($urandom % 8) == 0) ra = 5'd0;
               set_req(i, 1'b1, ra, $urandom);
            end
         end
         pend_set  = (($urandom % 3) == 0);
         pend_addr = 5'($urandom % 32);
         rs1       = 5'($urandom % 32);
         rs2       = 5'($urandom % 32);
         cyc(g);
         if (g >= 0) begin
            if (($urandom % 2) == 0) set_req(g, 1'b0, 5'd0, 32'd0);
            else set_req(g, 1'b1, 5'($urandom % 32), $urandom);
         end
      end
      valid = '0;
      pend_set = 1'b0;
      cyc(g);
      cyc(g);
      #20;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
